ring_guard: RTL
===============

Name: ring_guard

Overview:
Synthesizable two-ring privilege and protection unit between the CPU core and the program/data memories and register file.
- Tracks the current ring and supplies the program and data offsets.
- Checks user-mode jumps, memory addresses and register selects against parametrised privileged limits.
- Captures the first fault and either halts the core or traps to the kernel entrypoint.
- Replaces the ad-hoc, testbench-only ring enforcement with RTL that can sit in CPUTop.

Parameters:
PC_W, 16, program counter and jump target width
ADDR_W, 16, data memory address width
SEL_W, 5, register select width
RING0_ENTRY, 0, only legal kernel entry target; also the trap target
RING0_MEM_LIMIT, 255, last privileged data address; user raw addresses at or below it fault
RING0_REG_LIMIT, 3, last privileged register index
USER_PC_OFFSET, 16384, program offset applied in USER
USER_MEM_OFFSET, 256, data offset applied in USER
FAULT_MODE, 0, 0 = halt on fault, 1 = trap to kernel
CNT_W, 8, fault counter width

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high
io_jump  in  1  core takes a jump this cycle
io_jumpTarget  in  PC_W  jump target (virtual in USER)
io_syscallReq  in  1  syscall register nonzero
io_userEnter  in  1  kernel request to drop to USER (pulse)
io_memValid  in  1  data memory access this cycle
io_memAddr  in  ADDR_W  raw data address
io_regValid  in  1  aSel/bSel reads are meaningful
io_aSel  in  SEL_W  register read select A
io_bSel  in  SEL_W  register read select B
io_writeEnable  in  1  register write
io_writeSel  in  SEL_W  register write select
io_faultClear  in  1  kernel clears captured fault info
io_privileged  out  1  state is KERNEL
io_progOffset  out  PC_W  program memory offset
io_dataOffset  out  ADDR_W  data memory offset
io_halt  out  1  core must stop
io_trapRedirect  out  1  one-cycle forced jump to io_trapTarget
io_trapTarget  out  PC_W  equals RING0_ENTRY
io_faultValid  out  1  captured fault present
io_faultCause  out  3  cause code
io_faultAddr  out  max(PC_W,ADDR_W)  offending address or select
io_faultCount  out  CNT_W  saturating fault count

Behaviour:
- Clock and reset: one clock, `clock`. Reset is synchronous and active-high on `reset`.
- Reset values: state KERNEL, io_privileged=1, both offsets 0, io_halt=0, io_trapRedirect=0, io_faultValid=0, io_faultCause=0, io_faultAddr=0, io_faultCount=0.
- States: KERNEL, USER, TRAP, HALTED.
  - KERNEL → USER when io_userEnter=1. In USER, io_userEnter is ignored.
  - USER → KERNEL when io_jump=1, io_jumpTarget=RING0_ENTRY and io_syscallReq=1, with no violation in the same cycle.
  - USER → TRAP (FAULT_MODE=1) or HALTED (FAULT_MODE=0) on a violation.
  - TRAP → KERNEL after exactly one cycle.
  - HALTED is left only by reset.
- Offsets (combinational from state and inputs):
  - USER: progOffset=USER_PC_OFFSET and dataOffset=USER_MEM_OFFSET.
  - Otherwise both are 0.
  - Exception: progOffset is 0 in the same cycle as a legal syscall jump.
- Violations are checked only in USER, evaluated combinationally and registered at the clock edge. Causes in priority order:
  - 1 JUMP: physical target (target+USER_PC_OFFSET) overflows PC_W, unless the jump is a syscall jump.
  - 2 MEM: io_memValid and io_memAddr ≤ RING0_MEM_LIMIT.
  - 3 WRITE: io_writeEnable and io_writeSel ≤ RING0_REG_LIMIT.
  - 4 SEL_A: io_regValid and io_aSel ≤ limit.
  - 5 SEL_B: same check on io_bSel.
  - Only the highest-priority cause is recorded.
- Fault timing: a violation in cycle N gives, in cycle N+1:
  - state HALTED or TRAP;
  - io_halt=1 (held), or io_trapRedirect=1 for exactly one cycle;
  - io_privileged=1 in TRAP and thereafter.
- Fault capture:
  - Cause and address are latched only if io_faultValid=0, so the first fault wins.
  - io_faultAddr holds the raw jump target, memory address, or zero-extended select.
  - io_faultCount increments on every fault and saturates at 2^CNT_W-1.
  - io_faultClear (KERNEL only) clears valid, cause and address. A same-cycle new fault takes priority over the clear.
- A violation coinciding with a syscall jump is a fault; the syscall is not taken.
- Reset mid-fault or mid-trap returns to reset values, including the counter.

Decomposition:
- Package ring_guard_pkg holds:
  - the state enum (KERNEL, USER, TRAP, HALTED);
  - the 3-bit cause codes (NONE=0, JUMP, MEM, WRITE, SEL_A, SEL_B);
  - FAULT_HALT and FAULT_TRAP mode constants.
- Sub-module ring_violation_check: purely combinational limit compares plus priority encoder, outputting violation, cause and address.

Test Plan:
- Reset, io_userEnter=1 → next cycle io_privileged=0, progOffset=16384, dataOffset=256.
- USER, io_memValid=1, addr=0x00FF, FAULT_MODE=0 → next cycle io_halt=1, cause=2, faultAddr=0x00FF, count=1. io_halt stays 1 for 20 cycles; reset clears it.
- USER, jump to 0 with io_syscallReq=1 → same cycle progOffset=0, next cycle io_privileged=1. Jump to 0 with io_syscallReq=0 → no fault, stays USER.
- FAULT_MODE=1, USER, writeEnable with writeSel=2 and aSel=1 in the same cycle → cause=3, io_trapRedirect pulses 1 cycle with trapTarget=0, then KERNEL.
- Second fault while faultValid=1 → cause/address unchanged, count=2. io_faultClear in the same cycle as a third fault → new cause captured.
- USER jump target 0xC000 (+0x4000 overflows 16 bits) → cause=1, faultAddr=0xC000. Force 255 faults → count saturates at 255.

Source files
------------

// File: rtl/ring_guard_pkg.sv
// Shared types for the two-ring protection unit: ring states, fault cause codes
// and the fault-handling mode selectors.
package ring_guard_pkg;

  typedef enum logic [1:0] {
    KERNEL = 2'd0,
    USER   = 2'd1,
    TRAP   = 2'd2,
    HALTED = 2'd3
  } ring_state_e;

  typedef enum logic [2:0] {
    CAUSE_NONE  = 3'd0,
    CAUSE_JUMP  = 3'd1,
    CAUSE_MEM   = 3'd2,
    CAUSE_WRITE = 3'd3,
    CAUSE_SEL_A = 3'd4,
    CAUSE_SEL_B = 3'd5
  } fault_cause_e;

  localparam int FAULT_HALT = 0;
  localparam int FAULT_TRAP = 1;

endpackage

// File: rtl/ring_violation_check.sv
// Combinational user-mode limit checks with a fixed-priority encoder that picks
// the single cause (and offending address/select) to report.
module ring_violation_check
  import ring_guard_pkg::*;
#(
  parameter int PC_W            = 16,
  parameter int ADDR_W          = 16,
  parameter int SEL_W           = 5,
  parameter int RING0_ENTRY     = 0,
  parameter int RING0_MEM_LIMIT = 255,
  parameter int RING0_REG_LIMIT = 3,
  parameter int USER_PC_OFFSET  = 16384,
  parameter int FA_W            = 16
) (
  input  logic              user_mode,
  input  logic              jump,
  input  logic [PC_W-1:0]   jump_target,
  input  logic              syscall_req,
  input  logic              mem_valid,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic              reg_valid,
  input  logic [SEL_W-1:0]  a_sel,
  input  logic [SEL_W-1:0]  b_sel,
  input  logic              write_enable,
  input  logic [SEL_W-1:0]  write_sel,
  output logic              syscall_jump,
  output logic              violation,
  output fault_cause_e      cause,
  output logic [FA_W-1:0]   fault_addr
);

  // Largest virtual target whose physical address still fits in PC_W bits.
  localparam int JUMP_MAX = (1 << PC_W) - 1 - USER_PC_OFFSET;

  logic jump_bad;
  logic mem_bad;
  logic write_bad;
  logic a_bad;
  logic b_bad;

  assign syscall_jump = jump && syscall_req && (jump_target == PC_W'(RING0_ENTRY));

  assign jump_bad  = user_mode && jump && !syscall_jump && (jump_target > PC_W'(JUMP_MAX));
  assign mem_bad   = user_mode && mem_valid && (mem_addr <= ADDR_W'(RING0_MEM_LIMIT));
  assign write_bad = user_mode && write_enable && (write_sel <= SEL_W'(RING0_REG_LIMIT));
  assign a_bad     = user_mode && reg_valid && (a_sel <= SEL_W'(RING0_REG_LIMIT));
  assign b_bad     = user_mode && reg_valid && (b_sel <= SEL_W'(RING0_REG_LIMIT));

  always_comb begin
    violation  = 1'b1;
    cause      = CAUSE_NONE;
    fault_addr = '0;
    if (jump_bad) begin
      cause      = CAUSE_JUMP;
      fault_addr = FA_W'(jump_target);
    end else if (mem_bad) begin
      cause      = CAUSE_MEM;
      fault_addr = FA_W'(mem_addr);
    end else if (write_bad) begin
      cause      = CAUSE_WRITE;
      fault_addr = FA_W'(write_sel);
    end else if (a_bad) begin
      cause      = CAUSE_SEL_A;
      fault_addr = FA_W'(a_sel);
    end else if (b_bad) begin
      cause      = CAUSE_SEL_B;
      fault_addr = FA_W'(b_sel);
    end else begin
      violation  = 1'b0;
    end
  end

endmodule

// File: rtl/ring_guard.sv
// Two-ring privilege unit: tracks KERNEL/USER, supplies memory offsets, and
// captures the first protection fault before halting or trapping to the kernel.
module ring_guard
  import ring_guard_pkg::*;
#(
  parameter int PC_W            = 16,
  parameter int ADDR_W          = 16,
  parameter int SEL_W           = 5,
  parameter int RING0_ENTRY     = 0,
  parameter int RING0_MEM_LIMIT = 255,
  parameter int RING0_REG_LIMIT = 3,
  parameter int USER_PC_OFFSET  = 16384,
  parameter int USER_MEM_OFFSET = 256,
  parameter int FAULT_MODE      = 0,
  parameter int CNT_W           = 8
) (
  input  logic                                      clock,
  input  logic                                      reset,
  input  logic                                      io_jump,
  input  logic [PC_W-1:0]                           io_jumpTarget,
  input  logic                                      io_syscallReq,
  input  logic                                      io_userEnter,
  input  logic                                      io_memValid,
  input  logic [ADDR_W-1:0]                         io_memAddr,
  input  logic                                      io_regValid,
  input  logic [SEL_W-1:0]                          io_aSel,
  input  logic [SEL_W-1:0]                          io_bSel,
  input  logic                                      io_writeEnable,
  input  logic [SEL_W-1:0]                          io_writeSel,
  input  logic                                      io_faultClear,
  output logic                                      io_privileged,
  output logic [PC_W-1:0]                           io_progOffset,
  output logic [ADDR_W-1:0]                         io_dataOffset,
  output logic                                      io_halt,
  output logic                                      io_trapRedirect,
  output logic [PC_W-1:0]                           io_trapTarget,
  output logic                                      io_faultValid,
  output logic [2:0]                                io_faultCause,
  output logic [((PC_W > ADDR_W) ? PC_W : ADDR_W)-1:0] io_faultAddr,
  output logic [CNT_W-1:0]                          io_faultCount
);

  localparam int FA_W = (PC_W > ADDR_W) ? PC_W : ADDR_W;

  ring_state_e     state_reg, state_next;
  logic            fault_valid_reg;
  fault_cause_e    fault_cause_reg;
  logic [FA_W-1:0] fault_addr_reg;
  logic [CNT_W-1:0] fault_count_reg;

  logic            user_mode;
  logic            syscall_jump;
  logic            violation;
  fault_cause_e    viol_cause;
  logic [FA_W-1:0] viol_addr;
  logic            legal_syscall;

  assign user_mode     = (state_reg == USER);
  assign legal_syscall = user_mode && syscall_jump && !violation;

  ring_violation_check #(
    .PC_W            (PC_W),
    .ADDR_W          (ADDR_W),
    .SEL_W           (SEL_W),
    .RING0_ENTRY     (RING0_ENTRY),
    .RING0_MEM_LIMIT (RING0_MEM_LIMIT),
    .RING0_REG_LIMIT (RING0_REG_LIMIT),
    .USER_PC_OFFSET  (USER_PC_OFFSET),
    .FA_W            (FA_W)
  ) u_check (
    .user_mode    (user_mode),
    .jump         (io_jump),
    .jump_target  (io_jumpTarget),
    .syscall_req  (io_syscallReq),
    .mem_valid    (io_memValid),
    .mem_addr     (io_memAddr),
    .reg_valid    (io_regValid),
    .a_sel        (io_aSel),
    .b_sel        (io_bSel),
    .write_enable (io_writeEnable),
    .write_sel    (io_writeSel),
    .syscall_jump (syscall_jump),
    .violation    (violation),
    .cause        (viol_cause),
    .fault_addr   (viol_addr)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      KERNEL: if (io_userEnter) state_next = USER;
      USER: begin
        if (violation) begin
          state_next = (FAULT_MODE == FAULT_TRAP) ? TRAP : HALTED;
        end else if (syscall_jump) begin
          state_next = KERNEL;
        end
      end
      TRAP:    state_next = KERNEL;
      HALTED:  state_next = HALTED;
      default: state_next = HALTED;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg       <= KERNEL;
      fault_valid_reg <= 1'b0;
      fault_cause_reg <= CAUSE_NONE;
      fault_addr_reg  <= '0;
      fault_count_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (violation) begin
        if (fault_count_reg != {CNT_W{1'b1}}) begin
          fault_count_reg <= fault_count_reg + 1'b1;
        end
        // A clear arriving with a new fault still lets that fault be captured.
        if (!fault_valid_reg || io_faultClear) begin
          fault_valid_reg <= 1'b1;
          fault_cause_reg <= viol_cause;
          fault_addr_reg  <= viol_addr;
        end
      end else if (io_faultClear && state_reg == KERNEL) begin
        fault_valid_reg <= 1'b0;
        fault_cause_reg <= CAUSE_NONE;
        fault_addr_reg  <= '0;
      end
    end
  end

  assign io_privileged   = (state_reg != USER);
  assign io_progOffset   = (user_mode && !legal_syscall) ? PC_W'(USER_PC_OFFSET) : '0;
  assign io_dataOffset   = user_mode ? ADDR_W'(USER_MEM_OFFSET) : '0;
  assign io_halt         = (state_reg == HALTED);
  assign io_trapRedirect = (state_reg == TRAP);
  assign io_trapTarget   = PC_W'(RING0_ENTRY);
  assign io_faultValid   = fault_valid_reg;
  assign io_faultCause   = fault_cause_reg;
  assign io_faultAddr    = fault_addr_reg;
  assign io_faultCount   = fault_count_reg;

endmodule
